// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding word fetch, a one-entry decode
// buffer, and branch redirect with squash of wrong-path requests and data.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_addr_i,

    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,

    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        misaligned_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] ipc4_q, ipc4_d;
    logic            mis_q, mis_d;

    logic            redirect;
    logic [XLEN-1:0] br_target;

    assign redirect  = br_valid_i && br_taken_i;
    assign br_target = {br_addr_i[XLEN-1:2], 2'b00};

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_ADDR;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_ADDR;
            ipc4_q  <= RESET_ADDR + PC_STEP;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            mis_q   <= mis_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        mis_d   = redirect && (br_addr_i[1:0] != 2'b00);

        unique case (state_q)
            S_FETCH: begin
                // req_q is low only in the first cycle after reset; no request
                // has gone out then, so there is nothing to kill.
                if (req_q) begin
                    state_d = S_WAIT;
                    kill_d  = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        instr_d = imem_rdata_i;
                        ipc_d   = pc_q;
                        ipc4_d  = pc_q + PC_STEP;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || (valid_q && instr_ready_i)) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A taken branch wins over any buffer or response activity
        if (redirect) begin
            pc_d    = br_target;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    assign req_d = (state_d == S_FETCH);

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = ipc_q;
    assign pc_plus4_o    = ipc4_q;
    assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0, br_taken = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        ready = 1'b1;
    logic [31:0] instr, pc_out, pc4_out;
    logic        mis;

    logic        rst_w_n = 1'b0;
    logic        w_req, w_valid, w_mis;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_prev_req = 1'b0;
    logic [31:0] w_prev_addr = 32'h0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int lat = 1;
    bit spur = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_ADDR(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .br_valid_i(br_valid), .br_taken_i(br_taken), .br_addr_i(br_addr),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .instr_valid_o(instr_valid), .instr_ready_i(ready), .instr_o(instr),
        .pc_o(pc_out), .pc_plus4_o(pc4_out), .misaligned_o(mis)
    );

    fetch_unit #(.RESET_ADDR(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_w (
        .clk_i(clk), .rst_ni(rst_w_n),
        .br_valid_i(1'b0), .br_taken_i(1'b0), .br_addr_i(32'h0),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
        .instr_valid_o(w_valid), .instr_ready_i(1'b1), .instr_o(w_instr),
        .pc_o(w_pc), .pc_plus4_o(w_pc4), .misaligned_o(w_mis)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: returns word = address, lat cycles after the request
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t pend[$];

    always @(negedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr;
            void'(pend.pop_front());
        end
        if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_0BAD;
        end
        if (imem_req) pend.push_back('{imem_addr, cyc + lat});
    end

    always @(negedge clk) begin
        #1;
        w_rvalid    = w_prev_req;
        w_rdata     = w_prev_addr;
        w_prev_req  = w_req;
        w_prev_addr = w_addr;
    end

    // Reference model: outstanding-request flag, stale flag, buffer queue
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0, m_pc_o = 32'h0, m_tgt;
    bit          m_busy = 0, m_stale = 0, m_req = 0, m_mis = 0, m_redir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_pc_o = 32'h0;
            m_busy = 0; m_stale = 0; m_req = 0; m_mis = 0;
            mq.delete();
        end else begin
            m_redir = br_valid && br_taken;
            m_tgt   = br_addr & 32'hFFFF_FFFC;
            m_mis   = m_redir && (br_addr % 4 != 0);
            if (m_req) begin
                m_busy  = 1;
                m_stale = m_redir;
            end else if (m_busy) begin
                if (imem_rvalid) begin
                    m_busy = 0;
                    if (!m_stale && !m_redir) begin
                        mq.push_back('{imem_rdata, m_pc});
                        m_pc_o = m_pc;
                        m_pc   = m_pc + 32'd4;
                    end
                    m_stale = 0;
                end else if (m_redir) begin
                    m_stale = 1;
                end
            end else if (mq.size() != 0 && (m_redir || ready)) begin
                mq.delete();
            end
            if (m_redir) m_pc = m_tgt;
            m_req = !m_busy && mq.size() == 0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("m_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("m_addr", imem_addr, m_pc);
        chk("m_valid", 32'(instr_valid), 32'(mq.size() != 0));
        chk("m_instr", instr, (mq.size() != 0) ? mq[0].instr : NOP);
        chk("m_pc", pc_out, m_pc_o);
        chk("m_pc4", pc4_out, m_pc_o + 32'd4);
        chk("m_mis", 32'(mis), 32'(m_mis));
    end

    task automatic wait_req(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!imem_req && n < 60);
        if (!imem_req) chk({name, "_timeout"}, 32'(imem_req), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!instr_valid && n < 60);
        if (!instr_valid) chk({name, "_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac, c, freq, fval, n;
        bit saw;
        logic [31:0] addrs [3];

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc4", pc4_out, 32'h4);
        chk("rst_mis", 32'(mis), 32'd0);
        rst_n = 1'b1;

        // Back-to-back fetches with 1-cycle memory
        ac = 0; c = 0; freq = -1; fval = -1;
        while (ac < 3 && c < 40) begin
            @(negedge clk); c++;
            if (instr_valid && fval < 0) begin
                fval = c;
                chk("first_instr", instr, 32'h0);
                chk("first_pc", pc_out, 32'h0);
                chk("first_pc4", pc4_out, 32'h4);
            end
            if (imem_req) begin
                if (freq < 0) freq = c;
                addrs[ac] = imem_addr;
                ac++;
            end
        end
        chk("seq_addr0", addrs[0], 32'h0);
        chk("seq_addr1", addrs[1], 32'h4);
        chk("seq_addr2", addrs[2], 32'h8);
        chk("first_valid_lat", 32'(fval - freq), 32'd2);

        // Decode stall; spurious response and not-taken branch while holding
        ready = 1'b0;
        wait_valid("hold");
        chk("hold_instr0", instr, 32'h8);
        chk("hold_pc0", pc_out, 32'h8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            spur     = (i == 1);
            br_valid = (i == 3);
            br_taken = 1'b0;
            br_addr  = 32'h0BAD_0000;
            chk("hold_instr", instr, 32'h8);
            chk("hold_pc", pc_out, 32'h8);
            chk("hold_noreq", 32'(imem_req), 32'd0);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'hC);
        lat = 3;

        // Redirect while waiting on a 3-cycle response
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_addr = 32'h100;
        @(negedge clk);
        br_valid = 1'b0;
        saw = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (instr_valid) saw = 1;
        end while (!imem_req && n < 60);
        chk("rwait_req", 32'(imem_req), 32'd1);
        chk("rwait_addr", imem_addr, 32'h100);
        chk("rwait_dropped", 32'(saw), 32'd0);
        wait_valid("rwait_valid");
        chk("rwait_pc", pc_out, 32'h100);
        chk("rwait_instr", instr, 32'h100);
        lat = 2;

        // Redirect coincident with the response
        wait_req("rsame_pre");
        chk("rsame_pre_addr", imem_addr, 32'h104);
        @(negedge clk);
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_addr = 32'h200;
        @(negedge clk);
        br_valid = 1'b0;
        chk("rsame_valid", 32'(instr_valid), 32'd0);
        chk("rsame_req", 32'(imem_req), 32'd1);
        chk("rsame_addr", imem_addr, 32'h200);

        // Misaligned target
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_addr = 32'h302;
        @(negedge clk);
        br_valid = 1'b0;
        chk("mis_pulse", 32'(mis), 32'd1);
        @(negedge clk);
        chk("mis_clear", 32'(mis), 32'd0);
        chk("mis_req", 32'(imem_req), 32'd1);
        chk("mis_addr", imem_addr, 32'h300);

        // Redirect in the request cycle itself
        br_valid = 1'b1; br_taken = 1'b1; br_addr = 32'h500;
        @(negedge clk);
        br_valid = 1'b0;
        wait_req("rfetch");
        chk("rfetch_addr", imem_addr, 32'h500);

        // Redirect overrides a simultaneous decode handshake
        ready = 1'b0;
        wait_valid("rhold");
        chk("rhold_pc0", pc_out, 32'h500);
        chk("rhold_instr0", instr, 32'h500);
        ready = 1'b1;
        br_valid = 1'b1; br_taken = 1'b1; br_addr = 32'h400;
        @(negedge clk);
        br_valid = 1'b0;
        chk("rhold_valid", 32'(instr_valid), 32'd0);
        chk("rhold_instr", instr, NOP);
        chk("rhold_pc", pc_out, 32'h500);
        chk("rhold_req", 32'(imem_req), 32'd1);
        chk("rhold_addr", imem_addr, 32'h400);

        // PC wrap through a redirect to the top word
        @(negedge clk);
        br_valid = 1'b1; br_taken = 1'b1; br_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        br_valid = 1'b0;
        wait_req("wrap_top");
        chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap_valid");
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4_out, 32'h0);
        wait_req("wrap_next");
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Asynchronous reset while an instruction is held
        ready = 1'b0;
        wait_valid("arst_hold");
        chk("arst_pre_valid", 32'(instr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", instr, NOP);
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_pc4", pc4_out, 32'h4);
        chk("arst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        wait_req("arst_restart");
        chk("arst_restart_addr", imem_addr, 32'h0);

        // Asynchronous reset while waiting; late response must be ignored
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("wrst_valid", 32'(instr_valid), 32'd0);
        chk("wrst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req("wrst_restart");
        chk("wrst_restart_addr", imem_addr, 32'h0);
        wait_valid("wrst_valid2");
        chk("wrst_instr", instr, 32'h0);
        chk("wrst_pc", pc_out, 32'h0);

        // Instance reset at the top of the address space
        @(negedge clk);
        chk("w_rst_pc4", w_pc4, 32'h0);
        chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);
        chk("w_rst_valid", 32'(w_valid), 32'd0);
        rst_w_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!w_valid && n < 40);
        chk("w_valid", 32'(w_valid), 32'd1);
        chk("w_pc", w_pc, 32'hFFFF_FFFC);
        chk("w_instr", w_instr, 32'hFFFF_FFFC);
        chk("w_pc4", w_pc4, 32'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!w_req && n < 40);
        chk("w_next_req", 32'(w_req), 32'd1);
        chk("w_next_addr", w_addr, 32'h0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
